upc_input_ctrl: RTL
===================

// Module: upc_input_ctrl
// PURPOSE
//  Front-end control stage that sits directly upstream of the 4-bit up counter.
//  Turns raw button/switch inputs into clean 1-cycle ld/cen strobes and a load value.
//  Modes: manual (one count per button press) or auto (count on prescaler tick).
//  Consumes the counter's carry-out to optionally halt auto-run at terminal count.
// PARAMETERS
//  DATA_W          4      width of load value / par_o
//  PRESCALE_W      16     width of prescaler counter
//  PRESCALE_DIV    50000  clk cycles per tick (>=2, < 2**PRESCALE_W)
//  DEBOUNCE_TICKS  4      consecutive ticks a new level must hold to be accepted (>=1)
//  STOP_AT_TC      1      1: auto mode halts when co_i=1; 0: auto mode free-wraps
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       reset, asynchronous, active-low
//  btn_count_i  in   1       raw count button, active-high, asynchronous
//  btn_load_i   in   1       raw load button, active-high, asynchronous
//  sw_mode_i    in   1       raw mode switch: 0 manual, 1 auto
//  sw_val_i     in   DATA_W  raw load-value switches
//  co_i         in   1       carry-out from downstream counter (counter at all-ones)
//  ld_o         out  1       1-cycle parallel-load strobe to counter
//  cen_o        out  1       1-cycle count-enable strobe to counter
//  par_o        out  DATA_W  load value, valid whenever ld_o=1
//  tick_o       out  1       1-cycle prescaler tick
//  halted_o     out  1       1 while in HALT state
// BEHAVIOUR
//  Reset (rst=0, async, immediate): ld_o=0 cen_o=0 par_o=0 tick_o=0 halted_o=0;
//   prescaler=0, debounce counters=0, stable button levels=0, synchronizers=0, state=MANUAL.
//  Sync: btn_count_i, btn_load_i, sw_mode_i, sw_val_i each pass a 2-flop synchronizer.
//  Prescaler: counts 0..PRESCALE_DIV-1, wraps to 0; tick_o=1 in the cycle count==DIV-1.
//   First tick_o is PRESCALE_DIV cycles after rst deasserts.
//  Debounce (per button, evaluated only on tick): synced!=stable -> cnt++; cnt reaching
//   DEBOUNCE_TICKS -> stable<=synced, cnt<=0; synced==stable -> cnt<=0.
//   press = registered rising edge of stable (exactly 1 cycle); release makes no event.
//   Button held through reset release is accepted as one press after debounce.
//  Mode switch is synchronized only, not debounced.
//  FSM states MANUAL, RUN, HALT:
//   MANUAL: cen_o=count press; co_i ignored (counter wraps). mode=1 -> RUN.
//   RUN: cen_o=tick_o; if STOP_AT_TC=1 and co_i=1 when tick_o=1 -> HALT, no cen_o.
//        mode=0 -> MANUAL.
//   HALT: halted_o=1, cen_o=0; count press -> RUN (no cen_o on that press);
//         load press -> RUN after ld_o; mode=0 -> MANUAL.
//  Load: load press in any state -> ld_o=1 for 1 cycle, par_o=synced sw_val same cycle;
//   par_o holds that value until the next load.
//  Priority: ld_o and cen_o never both 1; load wins, the coincident count event is
//   dropped, not deferred.
//  Outputs registered: cen_o/ld_o assert 1 cycle after the press/tick event.
//  Latency raw edge -> strobe: 2 sync cycles + up to DEBOUNCE_TICKS+1 ticks + 2 cycles.
//  Glitch rejection: level held < DEBOUNCE_TICKS ticks produces no event.
// TESTING  (PRESCALE_DIV=4, DEBOUNCE_TICKS=2, STOP_AT_TC=1, DATA_W=4)
//  Reset: hold rst=0 10 cycles, release -> all outputs 0; tick_o first at cycle 4, then every 4.
//  Manual: mode=0, btn_count high 40 cycles -> exactly one cen_o pulse; 3-cycle glitch -> none.
//  Load: sw_val=4'hA, btn_load high 40 cycles -> one ld_o pulse, par_o=4'hA, cen_o=0 there.
//  Auto/halt: mode=1, co_i=0 -> cen_o every 4 cycles, 1 cycle after tick_o; co_i=1 -> halted_o=1,
//   no cen_o; count press -> halted_o=0, cen_o resumes on the next tick.
//  Collision: load and count pressed together -> ld_o once, zero cen_o for that event.
//  Reset mid-run: rst=0 during RUN -> ld_o/cen_o/tick_o/halted_o=0 at once, state MANUAL.

Source files
------------

// File: rtl/upc_input_ctrl.sv
// upc_input_ctrl
// Control stage in front of the 4-bit up counter. It turns raw buttons and
// switches into clean single-cycle load (ld_o) and count-enable (cen_o)
// strobes, plus the value to load (par_o).
//   manual mode : one count for each debounced press of the count button
//   auto mode   : one count on each prescaler tick; can stop at terminal count
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   btn_count_i  raw count button (active-high, asynchronous)
//   btn_load_i   raw load button (active-high, asynchronous)
//   sw_mode_i    raw mode switch: 0 manual, 1 auto
//   sw_val_i     raw load-value switches
//   co_i         carry-out from the counter (counter is at all-ones)
//   ld_o         1-cycle parallel-load strobe
//   cen_o        1-cycle count-enable strobe
//   par_o        load value; valid with ld_o, held until the next load
//   tick_o       1-cycle prescaler tick
//   halted_o     high while auto-run is halted at terminal count
module upc_input_ctrl #(
    parameter int unsigned DATA_W         = 4,
    parameter int unsigned PRESCALE_W     = 16,
    parameter int unsigned PRESCALE_DIV   = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned STOP_AT_TC     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_count_i,
    input  logic              btn_load_i,
    input  logic              sw_mode_i,
    input  logic [DATA_W-1:0] sw_val_i,
    input  logic              co_i,
    output logic              ld_o,
    output logic              cen_o,
    output logic [DATA_W-1:0] par_o,
    output logic              tick_o,
    output logic              halted_o
);

    localparam int unsigned DW  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned CNT = 0;
    localparam int unsigned LD  = 1;

    localparam logic [PRESCALE_W-1:0] LP_LAST = PRESCALE_W'(PRESCALE_DIV - 1);
    localparam logic [PRESCALE_W-1:0] LP_PRE  = PRESCALE_W'(PRESCALE_DIV - 2);
    localparam logic [DW-1:0]         LP_DBL  = DW'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {ST_MANUAL, ST_RUN, ST_HALT} state_t;

    // Input synchronizers; buttons packed as {load, count}.
    logic [1:0]        r_btn_s1, r_btn_s2;
    logic              r_mode_s1, r_mode_s2;
    logic [DATA_W-1:0] r_val_s1, r_val_s2;

    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_tick;

    logic [1:0]    r_stable, r_stable_d, r_press;
    logic [DW-1:0] r_dcnt [2];

    state_t            r_state;
    logic              r_ld, r_cen, r_halted;
    logic [DATA_W-1:0] r_par;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_s1  <= '0;
            r_btn_s2  <= '0;
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
            r_val_s1  <= '0;
            r_val_s2  <= '0;
        end else begin
            r_btn_s1  <= {btn_load_i, btn_count_i};
            r_btn_s2  <= r_btn_s1;
            r_mode_s1 <= sw_mode_i;
            r_mode_s2 <= r_mode_s1;
            r_val_s1  <= sw_val_i;
            r_val_s2  <= r_val_s1;
        end
    end

    // The tick register is loaded one count early so it is high exactly
    // while the prescaler sits at its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= (r_presc == LP_LAST) ? '0 : r_presc + PRESCALE_W'(1);
            r_tick  <= (r_presc == LP_PRE);
        end
    end

    // Debounce: a new level must be seen on DEBOUNCE_TICKS consecutive ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable   <= '0;
            r_stable_d <= '0;
            r_press    <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
            if (r_tick) begin
                for (int unsigned i = 0; i < 2; i++) begin
                    if (r_btn_s2[i] != r_stable[i]) begin
                        if (r_dcnt[i] == LP_DBL) begin
                            r_stable[i] <= r_btn_s2[i];
                            r_dcnt[i]   <= '0;
                        end else begin
                            r_dcnt[i] <= r_dcnt[i] + DW'(1);
                        end
                    end else begin
                        r_dcnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Load has priority: a count event coinciding with a load is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_MANUAL;
            r_ld     <= 1'b0;
            r_cen    <= 1'b0;
            r_halted <= 1'b0;
            r_par    <= '0;
        end else begin
            r_ld  <= 1'b0;
            r_cen <= 1'b0;
            if (r_press[LD]) begin
                r_ld  <= 1'b1;
                r_par <= r_val_s2;
            end
            case (r_state)
                ST_MANUAL: begin
                    if (r_mode_s2) begin
                        r_state <= ST_RUN;
                    end else if (r_press[CNT] && !r_press[LD]) begin
                        r_cen <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!r_mode_s2) begin
                        r_state <= ST_MANUAL;
                    end else if (r_tick) begin
                        if ((STOP_AT_TC != 0) && co_i) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else if (!r_press[LD]) begin
                            r_cen <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (!r_mode_s2) begin
                        r_state  <= ST_MANUAL;
                        r_halted <= 1'b0;
                    end else if (r_press[CNT] || r_press[LD]) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_MANUAL;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign ld_o     = r_ld;
    assign cen_o    = r_cen;
    assign par_o    = r_par;
    assign tick_o   = r_tick;
    assign halted_o = r_halted;

endmodule
